// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-bypass network.
// A history entry holds one producer's destination register and its result data.
package fwd_pkg;

   localparam int unsigned FWD_XLEN    = 32;
   localparam int unsigned FWD_REGW    = 5;
   localparam int unsigned SRC_REGFILE = 0;

   // History entries are sized by FWD_XLEN/FWD_REGW, so these bound the XLEN/REGW
   // that forward_net can carry.
   typedef struct packed {
      logic                valid;
      logic [FWD_REGW-1:0] rd;
      logic [FWD_XLEN-1:0] data;
   } hist_entry_t;

   function automatic int unsigned sel_w(input int unsigned depth, input int unsigned lanes);
      return $clog2(depth * lanes + 1);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// One operand's bypass mux: picks the youngest matching candidate or the regfile datum.
// Candidate index = stage*LANES + lane; its source code is that index plus one.
module fwd_select
   import fwd_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned REGW  = 5,
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 3,
   parameter int unsigned SELW  = 3
) (
   input  logic [REGW-1:0]                i_rs,
   input  logic [XLEN-1:0]                i_rf,
   input  hist_entry_t [DEPTH*LANES-1:0]  i_cand,
   output logic [XLEN-1:0]                o_op,
   output logic [SELW-1:0]                o_src
);

   // Scan oldest stage first and lowest lane first so later matches overwrite:
   // the survivor is the lowest stage, highest lane.
   always_comb begin
      o_op  = i_rf;
      o_src = SELW'(SRC_REGFILE);
      if (i_rs != '0) begin
         for (int unsigned k = DEPTH; k > 0; k--) begin
            for (int unsigned l = 0; l < LANES; l++) begin
               if (i_cand[(k-1)*LANES+l].valid &&
                   (i_cand[(k-1)*LANES+l].rd == FWD_REGW'(i_rs))) begin
                  o_op  = XLEN'(i_cand[(k-1)*LANES+l].data);
                  o_src = SELW'((k-1)*LANES + l + 1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/forward_net.sv
// Operand-bypass network: per-lane producer history (M, W, W+1, ...) resolved
// youngest-first onto both E-stage operands of every lane, plus a hit counter.
module forward_net
   import fwd_pkg::*;
#(
   parameter  int unsigned XLEN  = 32,
   parameter  int unsigned LANES = 2,
   parameter  int unsigned DEPTH = 3,
   parameter  int unsigned REGW  = 5,
   parameter  int unsigned CNTW  = 16,
   localparam int unsigned SELW  = sel_w(DEPTH, LANES)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall_i,
   input  logic                             flush_i,
   input  logic [LANES-1:0]                 wr_en_M,
   input  logic [LANES-1:0][REGW-1:0]       rd_M,
   input  logic [LANES-1:0][XLEN-1:0]       result_M,
   input  logic [LANES-1:0][REGW-1:0]       rs1_E,
   input  logic [LANES-1:0][REGW-1:0]       rs2_E,
   input  logic [LANES-1:0][XLEN-1:0]       rd1_E,
   input  logic [LANES-1:0][XLEN-1:0]       rd2_E,
   output logic [LANES-1:0][XLEN-1:0]       op1_E,
   output logic [LANES-1:0][XLEN-1:0]       op2_E,
   output logic [LANES-1:0][SELW-1:0]       src1_E,
   output logic [LANES-1:0][SELW-1:0]       src2_E,
   output logic [CNTW-1:0]                  fwd_hits
);

   localparam int unsigned NCAND = DEPTH * LANES;

   hist_entry_t [NCAND-1:0] w_cand;
   logic [CNTW-1:0]         r_hits;
   logic [CNTW:0]           w_sum;

   for (genvar l = 0; l < LANES; l++) begin : g_stage0
      assign w_cand[l] = '{valid: wr_en_M[l] && (rd_M[l] != '0),
                           rd:    FWD_REGW'(rd_M[l]),
                           data:  FWD_XLEN'(result_M[l])};
   end

   if (DEPTH > 1) begin : g_hist
      // r_hist[0] is W; flattening lane-minor lines up with the candidate index.
      hist_entry_t [DEPTH-2:0][LANES-1:0] r_hist;

      always_ff @(posedge clk) begin
         if (reset || flush_i) begin
            for (int unsigned k = 0; k < DEPTH-1; k++)
               for (int unsigned l = 0; l < LANES; l++)
                  r_hist[k][l].valid <= 1'b0;
         end else if (!stall_i) begin
            for (int unsigned l = 0; l < LANES; l++)
               r_hist[0][l] <= w_cand[l];
            for (int unsigned k = 1; k < DEPTH-1; k++)
               for (int unsigned l = 0; l < LANES; l++)
                  r_hist[k][l] <= r_hist[k-1][l];
         end
      end

      assign w_cand[NCAND-1:LANES] = r_hist;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fwd_select #(
         .XLEN (XLEN),
         .REGW (REGW),
         .LANES(LANES),
         .DEPTH(DEPTH),
         .SELW (SELW)
      ) u_sel1 (
         .i_rs  (rs1_E[l]),
         .i_rf  (rd1_E[l]),
         .i_cand(w_cand),
         .o_op  (op1_E[l]),
         .o_src (src1_E[l])
      );

      fwd_select #(
         .XLEN (XLEN),
         .REGW (REGW),
         .LANES(LANES),
         .DEPTH(DEPTH),
         .SELW (SELW)
      ) u_sel2 (
         .i_rs  (rs2_E[l]),
         .i_rf  (rd2_E[l]),
         .i_cand(w_cand),
         .o_op  (op2_E[l]),
         .o_src (src2_E[l])
      );
   end

   // One spare bit on the sum flags overflow for saturation.
   always_comb begin
      w_sum = {1'b0, r_hits};
      for (int unsigned l = 0; l < LANES; l++) begin
         w_sum = w_sum + (CNTW+1)'(src1_E[l] != '0) + (CNTW+1)'(src2_E[l] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hits <= '0;
      end else if (!stall_i && !flush_i) begin
         r_hits <= w_sum[CNTW] ? '1 : w_sum[CNTW-1:0];
      end
   end

   assign fwd_hits = r_hits;

endmodule
